// File: rtl/mc_mem_pkg.sv
// Shared constants and types for the multi-cycle processor memory.
// Imported by mc_memory and mc_mem_key_port.
package mc_mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int DATA_W     = 32;
    localparam int KEY_W      = 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [KEY_W-1:0]  byte_t;

    localparam word_t KEY_ADDR = 32'd147456;

    // Little-endian lane extract: lane 0 is bits [7:0].
    function automatic byte_t lane_byte(input word_t w, input logic [1:0] lane);
        return w[{lane, 3'b000} +: KEY_W];
    endfunction

endpackage

// File: rtl/mc_mem_key_port.sv
// Memory-mapped keyboard latch: async clear, sample capture, KEY_ADDR decode.
// Reads of the key word return the latch zero-extended; byte lanes 1-3 read 0.
module mc_mem_key_port
    import mc_mem_pkg::word_t;
    import mc_mem_pkg::byte_t;
#(
    parameter word_t KEY_ADDR = mc_mem_pkg::KEY_ADDR
) (
    input  logic  clock,
    input  logic  reset_n,
    input  word_t i_address,
    input  logic  i_byte_read,
    input  byte_t i_key,
    input  logic  i_sample,
    output logic  o_hit,
    output word_t o_rd
);

    byte_t r_key_latch;
    logic  w_lane0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key_latch <= '0;
        end else if (i_sample) begin
            r_key_latch <= i_key;
        end
    end

    assign o_hit   = (i_address[31:2] == KEY_ADDR[31:2]);
    assign w_lane0 = (i_address[1:0] == 2'd0);

    always_comb begin
        o_rd = '0;
        if (!i_byte_read || w_lane0) begin
            o_rd = {24'b0, r_key_latch};
        end
    end

endmodule

// File: rtl/mc_memory.sv
// Unified memory: byte main port,
// word display port, key register.
module mc_memory
  import mc_mem_pkg::word_t;
  import mc_mem_pkg::byte_t;
  import mc_mem_pkg::lane_byte;
  import mc_mem_pkg::WORD_BYTES;
  import mc_mem_pkg::DATA_W;
#(
  parameter int    DEPTH_WORDS = 16384,
  parameter word_t KEY_ADDR    = mc_mem_pkg::KEY_ADDR,
  parameter        INIT_FILE   = "mem_init.hex"
) (
  input  logic  clock,
  input  logic  reset_n,
  input  word_t address,
  input  logic  isWrite,
  input  logic  byteWrite,
  input  logic  byteRead,
  input  word_t writeData,
  output word_t RD,
  input  word_t displayAddr,
  output word_t displayData,
  input  byte_t key_reg,
  input  logic  sample
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam word_t MEM_BYTES =
    word_t'(WORD_BYTES * DEPTH_WORDS);
  localparam word_t MEM_WORDS =
    word_t'(DEPTH_WORDS);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  logic          w_in_range;
  logic          w_disp_in_range;
  logic          w_key_hit;
  logic          w_wr_en;
  logic [AW-1:0] w_idx;
  word_t         w_key_rd;
  word_t         w_rd_word;

  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      r_mem[i] = '0;
    end
  end

  mc_mem_key_port #(
    .KEY_ADDR(KEY_ADDR)
  ) u_key (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_address  (address),
    .i_byte_read(byteRead),
    .i_key      (key_reg),
    .i_sample   (sample),
    .o_hit      (w_key_hit),
    .o_rd       (w_key_rd)
  );

  assign w_in_range = (address < MEM_BYTES);
  assign w_disp_in_range =
    (displayAddr < MEM_WORDS);
  assign w_idx = address[AW+1:2];
  assign w_wr_en =
    isWrite && w_in_range && !w_key_hit;
  assign w_rd_word = r_mem[w_idx];

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      if (byteWrite) begin
        r_mem[w_idx][{address[1:0], 3'b000} +: 8]
          <= writeData[7:0];
      end else begin
        r_mem[w_idx] <= writeData;
      end
    end
  end

  always_comb begin
    RD = '0;
    if (w_key_hit) begin
      RD = w_key_rd;
    end else if (w_in_range) begin
      if (byteRead) begin
        RD = {24'b0,
              lane_byte(w_rd_word, address[1:0])};
      end else begin
        RD = w_rd_word;
      end
    end
  end

  always_comb begin
    displayData = '0;
    if (w_disp_in_range) begin
      displayData = r_mem[displayAddr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_mc_memory.sv
// Scoreboard bench for mc_memory: directed scenarios then random traffic
// checked against a sparse word-array reference model.
module tb_mc_memory;

    localparam int          DEPTH = 16384;
    localparam int unsigned NBYTES = 4 * DEPTH;
    localparam logic [31:0] KEYA = 32'd147456;

    logic        clock;
    logic        reset_n;
    logic [31:0] address;
    logic        isWrite;
    logic        byteWrite;
    logic        byteRead;
    logic [31:0] writeData;
    logic [31:0] RD;
    logic [31:0] displayAddr;
    logic [31:0] displayData;
    logic [7:0]  key_reg;
    logic        sample;

    mc_memory dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .address    (address),
        .isWrite    (isWrite),
        .byteWrite  (byteWrite),
        .byteRead   (byteRead),
        .writeData  (writeData),
        .RD         (RD),
        .displayAddr(displayAddr),
        .displayData(displayData),
        .key_reg    (key_reg),
        .sample     (sample)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    string       qn[$];
    logic [31:0] qr[$];
    logic [31:0] qd[$];

    // Reference state: sparse word store (unwritten = 0) and key byte.
    int unsigned m_mem[int unsigned];
    logic [7:0]  m_key;

    function automatic int unsigned m_get(input int unsigned wi);
        if (m_mem.exists(wi)) return m_mem[wi];
        return 0;
    endfunction

    function automatic logic [31:0] m_rd(input int unsigned a, input bit br);
        int unsigned w;
        if ((a / 4) == (KEYA / 4)) begin
            if (!br || (a % 4) == 0) return {24'b0, m_key};
            return 0;
        end
        if (a >= NBYTES) return 0;
        w = m_get(a / 4);
        if (br) return (w >> (8 * (a % 4))) & 255;
        return w;
    endfunction

    function automatic logic [31:0] m_disp(input int unsigned da);
        if (da >= DEPTH) return 0;
        return m_get(da);
    endfunction

    task automatic m_write(input int unsigned a, input bit bw, input int unsigned wd);
        int unsigned w;
        int unsigned sh;
        if (a >= NBYTES) return;
        if (bw) begin
            sh = 8 * (a % 4);
            w = m_get(a / 4);
            w = (w & ~(32'd255 << sh)) | ((wd & 255) << sh);
            m_mem[a / 4] = w;
        end else begin
            m_mem[a / 4] = wd;
        end
    endtask

    task automatic step(
        input logic [31:0] a, input bit w, input bit bw, input bit br,
        input logic [31:0] wd, input logic [31:0] da,
        input logic [7:0] k, input bit s, input bit rst, input string nm
    );
        @(posedge clock);
        #1;
        reset_n   = !rst;
        address   = a;
        isWrite   = w;
        byteWrite = bw;
        byteRead  = br;
        writeData = wd;
        displayAddr = da;
        key_reg   = k;
        sample    = s;
        if (rst) m_key = 8'd0;
        qn.push_back(nm);
        qr.push_back(m_rd(a, br));
        qd.push_back(m_disp(da));
        if (w) m_write(a, bw, wd);
        if (s && !rst) m_key = k;
    endtask

    task automatic rd(input logic [31:0] a, input bit br,
                      input logic [31:0] da, input string nm);
        step(a, 0, 0, br, 32'h0, da, 8'h0, 0, 0, nm);
    endtask

    always @(negedge clock) begin
        string       n;
        logic [31:0] er;
        logic [31:0] ed;
        if (qn.size() > 0) begin
            n  = qn.pop_front();
            er = qr.pop_front();
            ed = qd.pop_front();
            checks++;
            if (RD !== er) begin
                errors++;
                $display("FAIL %s RD: got %h expected %h", n, RD, er);
            end
            checks++;
            if (displayData !== ed) begin
                errors++;
                $display("FAIL %s displayData: got %h expected %h",
                         n, displayData, ed);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] da;
        int          sel;
        reset_n = 1'b0;
        address = '0;
        isWrite = 1'b0;
        byteWrite = 1'b0;
        byteRead = 1'b0;
        writeData = '0;
        displayAddr = '0;
        key_reg = '0;
        sample = 1'b0;
        m_key = 8'd0;

        step(KEYA, 0, 0, 0, 0, 0, 8'd55, 1, 1, "reset_key");
        rd(KEYA, 0, 0, "key_after_reset");

        step(32'd1000, 1, 0, 0, 32'd1024, 32'd250, 0, 0, 0, "wr1000_rbw");
        rd(32'd1000, 0, 32'd250, "rd1000");

        step(32'd10000, 1, 0, 0, 32'h11223344, 0, 0, 0, 0, "pre10000");
        step(32'd10001, 1, 1, 0, 32'hFFFFFFAB, 32'd2500, 0, 0, 0, "bw10001");
        rd(32'd10000, 0, 32'd2500, "word10000");
        rd(32'd10001, 1, 0, "byte10001");
        rd(32'd10003, 1, 0, "byte10003");

        step(KEYA, 0, 0, 0, 0, 0, 8'd100, 1, 0, "key_sample");
        step(KEYA, 0, 0, 0, 0, 0, 8'd7, 0, 0, "key_hold");
        step(KEYA, 1, 0, 0, 32'd1023, 0, 0, 0, 0, "key_wr");
        rd(KEYA, 0, 32'h9000, "key_after_wr");
        rd(KEYA, 1, 0, "key_byte0");
        rd(KEYA + 1, 1, 0, "key_byte1");
        rd(KEYA + 3, 0, 0, "key_word_lane3");

        step(KEYA, 0, 0, 0, 0, 32'd250, 8'd9, 1, 1, "reset_mid");
        rd(KEYA, 0, 32'd250, "key_zero");
        rd(32'd1000, 0, 0, "rd1000_keep");

        step(32'd70000, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, "oor_wr");
        rd(32'd70000, 0, 32'd1116, "oor_rd");
        rd(32'd4464, 0, 32'd250, "alias_rd");

        step(32'd65532, 1, 0, 0, 32'hCAFEF00D, 0, 0, 0, 0, "top_wr");
        rd(32'd65535, 1, 32'd16383, "top_byte3");
        rd(32'd65536, 0, 32'd16384, "edge_oor");
        rd(32'd65532, 0, 32'hFFFFFFFF, "top_word");

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) a = $urandom_range(0, 255);
            else if (sel == 6) a = $urandom_range(65528, 65535);
            else if (sel == 7) a = KEYA + $urandom_range(0, 3);
            else if (sel == 8) a = $urandom_range(65536, 70000);
            else a = $urandom();
            sel = $urandom_range(0, 5);
            if (sel < 4) da = $urandom_range(0, 63);
            else if (sel == 4) da = $urandom_range(16380, 16390);
            else da = $urandom();
            step(a, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom(), da,
                 8'($urandom()), $urandom_range(0, 1),
                 ($urandom_range(0, 31) == 0), "rand");
        end
        rd(32'd1000, 0, 32'd250, "final");

        for (int i = 0; i < 10 && qn.size() > 0; i++) @(posedge clock);
        if (qn.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending, expected 0", qn.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
